branch_flag_ctrl: RTL

//  Owns the NZCV condition-flag register and resolves branches in ID.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/zero_detect.sv | 40 ++++
 rtl/branch_flag_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: branch kinds, ARM condition codes, the NZCV flag layout
// and the branch/flag controller state encoding.
package cpu_pkg;

   typedef enum logic [2:0] {
      BR_NONE  = 3'd0,
      BR_B     = 3'd1,
      BR_BCOND = 3'd2,
      BR_CBZ   = 3'd3,
      BR_CBNZ  = 3'd4
   } br_type_e;

   typedef enum logic [3:0] {
      C_EQ = 4'd0,  C_NE = 4'd1,  C_HS = 4'd2,  C_LO = 4'd3,
      C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
      C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
      C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } bfc_state_e;

   // True when condition `cond` passes against flag set `f`.
   function automatic logic cond_holds(cond_e cond, flags_t f);
      logic gt;
      logic hi;
      logic r;
      gt = !f.z && (f.n == f.v);
      hi = f.c && !f.z;
      r  = 1'b1;
      case (cond)
         C_EQ: r = f.z;
         C_NE: r = !f.z;
         C_HS: r = f.c;
         C_LO: r = !f.c;
         C_MI: r = f.n;
         C_PL: r = !f.n;
         C_VS: r = f.v;
         C_VC: r = !f.v;
         C_HI: r = hi;
         C_LS: r = !hi;
         C_GE: r = (f.n == f.v);
         C_LT: r = (f.n != f.v);
         C_GT: r = gt;
         C_LE: r = !gt;
         C_AL: r = 1'b1;
         C_NV: r = 1'b1;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/zero_detect.sv
// Wide zero detector: balanced tree of 4-input ORs, inverted at the root.
// The input is zero-padded up to the next power of four.
module zero_detect #(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] data,
   output logic              is_zero
);

   localparam int L = (DATA_W <= 4) ? 1 : ($clog2(DATA_W) + 1) / 2;
   localparam int P = 4 ** L;

   // Offset of tree level k inside the flat node vector (level 1 = leaves' parents).
   function automatic int level_off(int k);
      int s;
      s = 0;
      for (int j = 1; j < k; j++) s += P >> (2 * j);
      return s;
   endfunction

   localparam int NODES = level_off(L + 1);

   logic [P-1:0]     pad;
   logic [NODES-1:0] tree;

   assign pad = P'(data);

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      for (genvar i = 0; i < (P >> (2 * k)); i++) begin : g_node
         if (k == 1) begin : g_leaf
            assign tree[level_off(1) + i] = |pad[4*i +: 4];
         end else begin : g_inner
            assign tree[level_off(k) + i] = |tree[level_off(k-1) + 4*i +: 4];
         end
      end
   end

   assign is_zero = ~tree[NODES-1];

endmodule

// File: rtl/branch_flag_ctrl.sv
// NZCV flag register plus ID-stage branch resolution, with a one-cycle
// B.cond interlock when the flags it needs are still being produced in EX.
module branch_flag_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ex_valid,
   input  logic              ex_setflags,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_carry,
   input  logic              ex_overflow,
   input  logic              id_valid,
   input  logic [2:0]        id_br_type,
   input  logic [3:0]        id_cond,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic              id_rt_hazard,
   output logic              stall,
   output logic              br_taken,
   output logic [3:0]        flags_q,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   bfc_state_e state_q, state_d;
   flags_t     flags_r;
   br_type_e   br_type;
   cond_e      cond;

   logic ex_zero;
   logic rt_zero;
   logic flag_we;
   logic stall_c;
   logic resolve;
   logic taken_c;
   logic counted;

   assign br_type = br_type_e'(id_br_type);
   assign cond    = cond_e'(id_cond);
   assign flag_we = ex_valid && ex_setflags;
   assign flags_q = flags_r;

   zero_detect #(.DATA_W(DATA_W)) u_ex_zero (
      .data    (ex_result),
      .is_zero (ex_zero)
   );

   zero_detect #(.DATA_W(DATA_W)) u_rt_zero (
      .data    (id_rt_val),
      .is_zero (rt_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // HOLD always lasts one cycle: its bubble cannot write flags, so the
   // B.cond held in ID sees final flags_q there.
   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      resolve = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (id_valid && (br_type == BR_BCOND) && flag_we) begin
               stall_c = 1'b1;
               state_d = ST_HOLD;
            end else if (id_valid && ((br_type == BR_CBZ) || (br_type == BR_CBNZ))
                         && id_rt_hazard) begin
               stall_c = 1'b1;
            end else begin
               resolve = id_valid;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
            resolve = id_valid;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      taken_c = 1'b0;
      counted = 1'b0;
      case (br_type)
         BR_B: begin
            taken_c = 1'b1;
            counted = 1'b1;
         end
         BR_BCOND: begin
            taken_c = cond_holds(cond, flags_r);
            counted = 1'b1;
         end
         BR_CBZ: begin
            taken_c = rt_zero;
            counted = 1'b1;
         end
         BR_CBNZ: begin
            taken_c = !rt_zero;
            counted = 1'b1;
         end
         default: begin
            taken_c = 1'b0;
            counted = 1'b0;
         end
      endcase
   end

   assign stall    = reset_n && stall_c;
   assign br_taken = reset_n && resolve && taken_c;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flags_r <= '0;
      end else if (flag_we) begin
         flags_r <= '{n: ex_result[DATA_W-1], z: ex_zero, c: ex_carry, v: ex_overflow};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         br_cnt    <= '0;
         taken_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (resolve && counted) br_cnt    <= br_cnt + CNT_W'(1);
         if (br_taken)           taken_cnt <= taken_cnt + CNT_W'(1);
         if (stall)              stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
